// File: rtl/reg_dst_pipe.sv
// reg_dst_pipe: register-file destination select plus a DEPTH-stage
// destination/write-enable tracking pipeline (EX..WB).
// Optional forwarding-match unit enabled by defining REG_DST_FWD_EN;
// without it hit_a/hit_b are tied low and the port list is unchanged.
module reg_dst_pipe #(
  parameter int unsigned AW        = 5,
  parameter int unsigned DEPTH     = 3,
  parameter int unsigned LINK_ADDR = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic [1:0]       sel,
  input  logic [AW-1:0]    rt,
  input  logic [AW-1:0]    rd,
  input  logic             reg_write,
  input  logic [AW-1:0]    src_a,
  input  logic [AW-1:0]    src_b,
  output logic [AW-1:0]    dst_comb,
  output logic [AW-1:0]    dst_out,
  output logic             we_out,
  output logic [DEPTH-1:0] hit_a,
  output logic [DEPTH-1:0] hit_b
);

  logic [AW-1:0]    r_dst [DEPTH];
  logic [DEPTH-1:0] r_we;
  logic             w_we_eff;

  // Destination select; sel=11 means no destination
  always_comb begin
    dst_comb = '0;
    case (sel)
      2'b00:   dst_comb = AW'(LINK_ADDR);
      2'b01:   dst_comb = rt;
      2'b10:   dst_comb = rd;
      default: dst_comb = '0;
    endcase
  end

  // Register 0 is never written
  assign w_we_eff = reg_write && (sel != 2'b11) && (dst_comb != '0);

  // Pipeline stages: flush bubbles stage 0, stall freezes everything else
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_dst[i] <= '0;
        r_we[i]  <= 1'b0;
      end
    end else begin
      if (flush) begin
        r_dst[0] <= '0;
        r_we[0]  <= 1'b0;
      end else if (!stall) begin
        r_dst[0] <= dst_comb;
        r_we[0]  <= w_we_eff;
      end
      if (!stall) begin
        for (int i = 1; i < int'(DEPTH); i++) begin
          r_dst[i] <= r_dst[i-1];
          r_we[i]  <= r_we[i-1];
        end
      end
    end
  end

  assign dst_out = r_dst[DEPTH-1];
  assign we_out  = r_we[DEPTH-1];

`ifdef REG_DST_FWD_EN
  // Per-stage match of both source addresses against in-flight writes
  always_comb begin
    hit_a = '0;
    hit_b = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      hit_a[i] = r_we[i] && (r_dst[i] == src_a) && (src_a != '0);
      hit_b[i] = r_we[i] && (r_dst[i] == src_b) && (src_b != '0);
    end
  end
`else
  logic w_unused_src;

  assign hit_a        = '0;
  assign hit_b        = '0;
  assign w_unused_src = ^{src_a, src_b};
`endif

endmodule
